// File: rtl/tlb_port_arbiter.sv
// Shares one TLB lookup port between I and D sides (round-robin, one walk at a time) and serialises base writes between walks.
// Grant 1 cycle after eligible lookup, ack 1 cycle after tlb ack; requesters hold lookup until ack. Optional micro-cache: TLB_ARB_MICRO_EN.
module tlb_port_arbiter #(
  parameter int VA_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [VA_W-1:0] i_addr_i,
  input  logic            i_lookup,
  output logic [31:0]     i_ent_o,
  output logic            i_ack_o,
  output logic            i_fault_o,
  input  logic [VA_W-1:0] d_addr_i,
  input  logic            d_lookup,
  output logic [31:0]     d_ent_o,
  output logic            d_ack_o,
  output logic            d_fault_o,
  output logic [VA_W-1:0] fault_addr_o,
  input  logic [31:0]     base_i,
  input  logic            base_we,
  output logic            base_busy_o,
  output logic [VA_W-1:0] tlb_addr_o,
  output logic            tlb_lookup_o,
  input  logic [31:0]     tlb_ent_i,
  input  logic            tlb_ack_i,
  input  logic            tlb_fault_i,
  input  logic [VA_W-1:0] tlb_fault_addr_i,
  output logic [31:0]     tlb_base_o,
  output logic            tlb_base_we_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DRAIN, ST_BASE} state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              i_arm_q, i_arm_d;
  logic              d_arm_q, d_arm_d;
  logic [VA_W-1:0]   addr_q, addr_d;
  logic              lookup_q, lookup_d;
  logic [31:0]       i_ent_q, i_ent_d;
  logic [31:0]       d_ent_q, d_ent_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              i_flt_q, i_flt_d;
  logic              d_flt_q, d_flt_d;
  logic [VA_W-1:0]   fault_addr_q, fault_addr_d;
  logic              pend_q, pend_d;
  logic [31:0]       base_q, base_d;

  logic              i_elig, d_elig;
  logic              i_hit, d_hit;
  logic              i_req, d_req;
  logic              gnt_d;

  // last_q doubles as the owner of the walk in flight; the owner must not be served twice
  assign i_elig = i_arm_q & i_lookup & ~((state_q == ST_REQ) & ~last_q);
  assign d_elig = d_arm_q & d_lookup & ~((state_q == ST_REQ) &  last_q);

`ifdef TLB_ARB_MICRO_EN
  localparam int TAG_W = VA_W - 12;

  logic              i_cv_q, i_cv_d;
  logic              d_cv_q, d_cv_d;
  logic [TAG_W-1:0]  i_ctag_q, i_ctag_d;
  logic [TAG_W-1:0]  d_ctag_q, d_ctag_d;
  logic [31:0]       i_cent_q, i_cent_d;
  logic [31:0]       d_cent_q, d_cent_d;

  // A write in the same cycle already invalidates the entry, so its value is not trusted
  assign i_hit = i_elig & i_cv_q & ~base_we & (i_ctag_q == i_addr_i[VA_W-1:12]);
  assign d_hit = d_elig & d_cv_q & ~base_we & (d_ctag_q == d_addr_i[VA_W-1:12]);
`else
  assign i_hit = 1'b0;
  assign d_hit = 1'b0;
`endif

  assign i_req = i_elig & ~i_hit;
  assign d_req = d_elig & ~d_hit;
  assign gnt_d = (i_req & d_req) ? ~last_q : d_req;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    addr_d       = addr_q;
    lookup_d     = lookup_q;
    i_ent_d      = i_ent_q;
    d_ent_d      = d_ent_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    i_flt_d      = 1'b0;
    d_flt_d      = 1'b0;
    fault_addr_d = fault_addr_q;
    pend_d       = pend_q;
    base_d       = base_q;
`ifdef TLB_ARB_MICRO_EN
    i_cv_d   = i_cv_q;
    d_cv_d   = d_cv_q;
    i_ctag_d = i_ctag_q;
    d_ctag_d = d_ctag_q;
    i_cent_d = i_cent_q;
    d_cent_d = d_cent_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          state_d = ST_BASE;
        end else if (i_req | d_req) begin
          last_d   = gnt_d;
          addr_d   = gnt_d ? d_addr_i : i_addr_i;
          lookup_d = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (tlb_ack_i | tlb_fault_i) begin
          lookup_d = 1'b0;
          state_d  = ST_DRAIN;
          if (tlb_fault_i) begin
            fault_addr_d = tlb_fault_addr_i;
          end
          if (last_q) begin
            d_ack_d = 1'b1;
            d_flt_d = tlb_fault_i;
            d_ent_d = tlb_ent_i;
          end else begin
            i_ack_d = 1'b1;
            i_flt_d = tlb_fault_i;
            i_ent_d = tlb_ent_i;
          end
`ifdef TLB_ARB_MICRO_EN
          if (!tlb_fault_i) begin
            if (last_q) begin
              d_cv_d   = 1'b1;
              d_ctag_d = addr_q[VA_W-1:12];
              d_cent_d = tlb_ent_i;
            end else begin
              i_cv_d   = 1'b1;
              i_ctag_d = addr_q[VA_W-1:12];
              i_cent_d = tlb_ent_i;
            end
          end
`endif
        end
      end
      ST_DRAIN: begin
        if (!tlb_ack_i && !tlb_fault_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_BASE: begin
        pend_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef TLB_ARB_MICRO_EN
    if (i_hit) begin
      i_ack_d = 1'b1;
      i_flt_d = 1'b0;
      i_ent_d = i_cent_q;
    end
    if (d_hit) begin
      d_ack_d = 1'b1;
      d_flt_d = 1'b0;
      d_ent_d = d_cent_q;
    end
`endif

    // A write landing during the BASE pulse re-arms pending so it is not lost
    if (base_we) begin
      pend_d = 1'b1;
      base_d = base_i;
`ifdef TLB_ARB_MICRO_EN
      i_cv_d = 1'b0;
      d_cv_d = 1'b0;
`endif
    end

    i_arm_d = ~i_lookup | (i_arm_q & ~i_ack_d);
    d_arm_d = ~d_lookup | (d_arm_q & ~d_ack_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      last_q       <= 1'b1;
      i_arm_q      <= 1'b1;
      d_arm_q      <= 1'b1;
      addr_q       <= '0;
      lookup_q     <= 1'b0;
      i_ent_q      <= '0;
      d_ent_q      <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_flt_q      <= 1'b0;
      d_flt_q      <= 1'b0;
      fault_addr_q <= '0;
      pend_q       <= 1'b0;
      base_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      i_arm_q      <= i_arm_d;
      d_arm_q      <= d_arm_d;
      addr_q       <= addr_d;
      lookup_q     <= lookup_d;
      i_ent_q      <= i_ent_d;
      d_ent_q      <= d_ent_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      i_flt_q      <= i_flt_d;
      d_flt_q      <= d_flt_d;
      fault_addr_q <= fault_addr_d;
      pend_q       <= pend_d;
      base_q       <= base_d;
    end
  end

`ifdef TLB_ARB_MICRO_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_cv_q   <= 1'b0;
      d_cv_q   <= 1'b0;
      i_ctag_q <= '0;
      d_ctag_q <= '0;
      i_cent_q <= '0;
      d_cent_q <= '0;
    end else begin
      i_cv_q   <= i_cv_d;
      d_cv_q   <= d_cv_d;
      i_ctag_q <= i_ctag_d;
      d_ctag_q <= d_ctag_d;
      i_cent_q <= i_cent_d;
      d_cent_q <= d_cent_d;
    end
  end
`endif

  assign i_ent_o       = i_ent_q;
  assign d_ent_o       = d_ent_q;
  assign i_ack_o       = i_ack_q;
  assign d_ack_o       = d_ack_q;
  assign i_fault_o     = i_flt_q;
  assign d_fault_o     = d_flt_q;
  assign fault_addr_o  = fault_addr_q;
  assign base_busy_o   = pend_q;
  assign tlb_addr_o    = addr_q;
  assign tlb_lookup_o  = lookup_q;
  assign tlb_base_o    = base_q;
  assign tlb_base_we_o = (state_q == ST_BASE);

endmodule

// File: tb/tb_tlb_port_arbiter.sv
// Bench for tlb_port_arbiter: directed timing steps plus randomized requester traffic against a TLB model.
module tb_tlb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_addr_i, d_addr_i;
  logic        i_lookup, d_lookup;
  logic [31:0] i_ent_o, d_ent_o;
  logic        i_ack_o, d_ack_o, i_fault_o, d_fault_o;
  logic [31:0] fault_addr_o;
  logic [31:0] base_i;
  logic        base_we;
  logic        base_busy_o;
  logic [31:0] tlb_addr_o;
  logic        tlb_lookup_o;
  logic [31:0] tlb_ent_i;
  logic        tlb_ack_i, tlb_fault_i;
  logic [31:0] tlb_fault_addr_i;
  logic [31:0] tlb_base_o;
  logic        tlb_base_we_o;

  int errors = 0;
  int checks = 0;
  int lat    = 1;
  int walks  = 0;

  always #5 clk = ~clk;

  tlb_port_arbiter #(.VA_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_addr_i(i_addr_i), .i_lookup(i_lookup), .i_ent_o(i_ent_o), .i_ack_o(i_ack_o), .i_fault_o(i_fault_o),
    .d_addr_i(d_addr_i), .d_lookup(d_lookup), .d_ent_o(d_ent_o), .d_ack_o(d_ack_o), .d_fault_o(d_fault_o),
    .fault_addr_o(fault_addr_o), .base_i(base_i), .base_we(base_we), .base_busy_o(base_busy_o),
    .tlb_addr_o(tlb_addr_o), .tlb_lookup_o(tlb_lookup_o), .tlb_ent_i(tlb_ent_i), .tlb_ack_i(tlb_ack_i),
    .tlb_fault_i(tlb_fault_i), .tlb_fault_addr_i(tlb_fault_addr_i),
    .tlb_base_o(tlb_base_o), .tlb_base_we_o(tlb_base_we_o)
  );

  // Page-table contents of the modelled TLB
  function automatic logic [31:0] ent_of(input logic [31:0] a);
    return {a[27:12], 16'h0001};
  endfunction

  function automatic logic fault_of(input logic [31:0] a);
    return a[13] & ~a[12];
  endfunction

  // TLB model: answers a lookup 'lat' cycles after seeing it, one-cycle ack or fault
  initial begin : tlb_model
    int cnt;
    cnt = 0;
    tlb_ack_i = 1'b0;
    tlb_fault_i = 1'b0;
    tlb_ent_i = '0;
    tlb_fault_addr_i = '0;
    forever begin
      @(negedge clk);
      if (tlb_ack_i || tlb_fault_i) begin
        tlb_ack_i = 1'b0;
        tlb_fault_i = 1'b0;
        cnt = 0;
      end else if (tlb_lookup_o) begin
        if (cnt >= lat) begin
          walks++;
          tlb_ent_i = ent_of(tlb_addr_o);
          if (fault_of(tlb_addr_o)) begin
            tlb_fault_i = 1'b1;
            tlb_fault_addr_i = tlb_addr_o;
          end else begin
            tlb_ack_i = 1'b1;
          end
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h, required 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // sel: 0 i_ack_o, 1 d_ack_o, 2 tlb_lookup_o, 3 tlb_base_we_o
  task automatic wait_for(input int sel, input int budget, input string tag, output int cyc);
    logic seen;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < budget) begin
      @(negedge clk);
      cyc++;
      case (sel)
        0: seen = i_ack_o;
        1: seen = d_ack_o;
        2: seen = tlb_lookup_o;
        default: seen = tlb_base_we_o;
      endcase
    end
    checks++;
    assert (seen === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed no event within %0d cycles, required one", tag, cyc);
    end
  endtask

  initial begin : main
    int cyc, dup, pulses, pulse_at, dgrant_at, acks, w0;
    logic dseen;
    int st [2];
    int wt [2];
    logic [31:0] ra [2];
    logic ack_p, flt_p;
    logic [31:0] ent_p;

    rst = 1'b0;
    i_addr_i = '0; d_addr_i = '0; i_lookup = 1'b0; d_lookup = 1'b0;
    base_i = '0; base_we = 1'b0;
    #1;
    chk("rst_tlb_lookup", tlb_lookup_o, 0);
    chk("rst_i_ack", i_ack_o, 0);
    chk("rst_d_ack", d_ack_o, 0);
    chk("rst_base_busy", base_busy_o, 0);
    chk("rst_base_we", tlb_base_we_o, 0);
    chk("rst_tlb_addr", tlb_addr_o, 0);
    tick(2);
    rst = 1'b1;
    tick(1);

    // Simultaneous requests after reset: I wins, D follows right after DRAIN
    lat = 1;
    i_addr_i = 32'h0000_5000; d_addr_i = 32'h0000_7000;
    i_lookup = 1'b1; d_lookup = 1'b1;
    tick(1);
    chk("b1_lookup", tlb_lookup_o, 1);
    chk("b1_first_is_i", tlb_addr_o, 32'h0000_5000);
    wait_for(0, 10, "b1_i_ack", cyc);
    chk("b1_i_ack_cycle", cyc, 2);
    chk("b1_i_ent", i_ent_o, ent_of(32'h0000_5000));
    chk("b1_d_quiet", d_ack_o, 0);
    i_lookup = 1'b0;
    tick(1);
    chk("b1_d_not_yet", tlb_lookup_o, 0);
    tick(1);
    chk("b1_d_granted", tlb_lookup_o, 1);
    chk("b1_d_addr", tlb_addr_o, 32'h0000_7000);
    wait_for(1, 10, "b1_d_ack", cyc);
    chk("b1_d_ent", d_ent_o, ent_of(32'h0000_7000));
    d_lookup = 1'b0;
    tick(2);

    // Single I lookup, TLB acks 3 cycles after grant; held lookup must not re-issue
    lat = 2;
    i_addr_i = 32'h0000_1000; i_lookup = 1'b1;
    tick(1);
    chk("a_lookup", tlb_lookup_o, 1);
    chk("a_addr", tlb_addr_o, 32'h0000_1000);
    wait_for(0, 10, "a_i_ack", cyc);
    chk("a_ack_cycle", cyc, 3);
    chk("a_i_ent", i_ent_o, 32'h0001_0001);
    chk("a_i_fault", i_fault_o, 0);
    chk("a_lookup_dropped", tlb_lookup_o, 0);
    chk("a_d_ack_quiet", d_ack_o, 0);
    chk("a_d_ent_untouched", d_ent_o, ent_of(32'h0000_7000));
    dup = 0;
    repeat (4) begin
      tick(1);
      if (tlb_lookup_o || i_ack_o) dup++;
    end
    chk("a_no_duplicate", dup, 0);
    i_lookup = 1'b0;
    tick(2);

    // Last grant was I, so simultaneous requests now go D first
    lat = 1;
    i_addr_i = 32'h0000_9000; d_addr_i = 32'h0000_B000;
    i_lookup = 1'b1; d_lookup = 1'b1;
    tick(1);
    chk("b2_first_is_d", tlb_addr_o, 32'h0000_B000);
    wait_for(1, 10, "b2_d_ack", cyc);
    d_lookup = 1'b0;
    wait_for(2, 10, "b2_i_grant", cyc);
    chk("b2_i_grant_cycle", cyc, 2);
    chk("b2_i_addr", tlb_addr_o, 32'h0000_9000);
    wait_for(0, 10, "b2_i_ack", cyc);
    chk("b2_i_ent", i_ent_o, ent_of(32'h0000_9000));
    i_lookup = 1'b0;
    tick(2);

    // D page fault
    d_addr_i = 32'h0000_2000; d_lookup = 1'b1;
    wait_for(1, 10, "c_d_ack", cyc);
    chk("c_d_fault", d_fault_o, 1);
    chk("c_fault_addr", fault_addr_o, 32'h0000_2000);
    chk("c_i_ack_quiet", i_ack_o, 0);
    d_lookup = 1'b0;
    tick(1);
    chk("c_ack_pulse", d_ack_o, 0);
    chk("c_fault_pulse", d_fault_o, 0);
    tick(1);

    // Base write while idle: pulse two cycles later
    base_i = 32'h0005_0000; base_we = 1'b1;
    tick(1);
    base_we = 1'b0;
    chk("bi_we_early", tlb_base_we_o, 0);
    chk("bi_busy", base_busy_o, 1);
    tick(1);
    chk("bi_we", tlb_base_we_o, 1);
    chk("bi_base", tlb_base_o, 32'h0005_0000);
    tick(1);
    chk("bi_we_once", tlb_base_we_o, 0);
    chk("bi_busy_clear", base_busy_o, 0);

    // Two base writes during a walk merge into one pulse, ahead of the waiting D request
    lat = 4;
    i_addr_i = 32'h0000_3000; i_lookup = 1'b1;
    tick(1);
    chk("bw_lookup", tlb_lookup_o, 1);
    base_i = 32'h0003_0000; base_we = 1'b1;
    tick(1);
    base_i = 32'h0004_0000;
    d_addr_i = 32'h0000_D000; d_lookup = 1'b1;
    tick(1);
    base_we = 1'b0;
    chk("bw_busy", base_busy_o, 1);
    pulses = 0; pulse_at = -1; dgrant_at = -1; dseen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (i_ack_o) i_lookup = 1'b0;
      if (d_ack_o) begin
        d_lookup = 1'b0;
        dseen = 1'b1;
      end
      if (tlb_base_we_o) begin
        pulses++;
        pulse_at = k;
        chk("bw_base_value", tlb_base_o, 32'h0004_0000);
      end
      if (tlb_lookup_o && tlb_addr_o == 32'h0000_D000 && dgrant_at < 0) dgrant_at = k;
    end
    chk("bw_single_pulse", pulses, 1);
    chk("bw_base_before_grant", (dgrant_at > pulse_at) && (pulse_at >= 0), 1);
    chk("bw_busy_clear", base_busy_o, 0);
    chk("bw_d_completed", dseen, 1);
    tick(1);

    // Asynchronous reset mid-walk clears outputs at once
    lat = 20;
    i_addr_i = 32'h0000_C000; i_lookup = 1'b1;
    wait_for(2, 10, "e_grant", cyc);
    #1;
    rst = 1'b0;
    #1;
    chk("e_tlb_lookup", tlb_lookup_o, 0);
    chk("e_tlb_addr", tlb_addr_o, 0);
    chk("e_i_ent", i_ent_o, 0);
    chk("e_d_ent", d_ent_o, 0);
    chk("e_fault_addr", fault_addr_o, 0);
    chk("e_tlb_base", tlb_base_o, 0);
    i_lookup = 1'b0;
    tick(1);
    rst = 1'b1;
    lat = 1;
    tick(1);
    i_lookup = 1'b1;
    tick(1);
    chk("e_regrant", tlb_lookup_o, 1);
    wait_for(0, 10, "e_i_ack", cyc);
    chk("e_i_ent_after", i_ent_o, ent_of(32'h0000_C000));
    i_lookup = 1'b0;
    tick(2);

`ifdef TLB_ARB_MICRO_EN
    // Micro-cache: repeat hit returns next cycle without a walk; base write forces a new walk
    lat = 2;
    i_addr_i = 32'h0000_1000; i_lookup = 1'b1;
    wait_for(0, 10, "m_first_ack", cyc);
    i_lookup = 1'b0;
    tick(1);
    i_lookup = 1'b1;
    tick(1);
    chk("m_hit_ack", i_ack_o, 1);
    chk("m_hit_ent", i_ent_o, 32'h0001_0001);
    chk("m_hit_no_walk", tlb_lookup_o, 0);
    i_lookup = 1'b0;
    tick(1);
    base_i = 32'h0006_0000; base_we = 1'b1;
    tick(1);
    base_we = 1'b0;
    i_lookup = 1'b1;
    wait_for(2, 10, "m_walk_after_base", cyc);
    chk("m_walk_addr", tlb_addr_o, 32'h0000_1000);
    wait_for(0, 10, "m_second_ack", cyc);
    i_lookup = 1'b0;
    tick(2);
`endif

    // Randomized traffic: every ack must carry the model's entry/fault for that requester's address
    st[0] = 0; st[1] = 0; wt[0] = 0; wt[1] = 0;
    ra[0] = '0; ra[1] = '0;
    acks = 0;
    w0 = walks;
    for (int k = 0; k < 3000; k++) begin
      tick(1);
      lat = $urandom_range(0, 4);
      for (int p = 0; p < 2; p++) begin
        ack_p = (p == 0) ? i_ack_o : d_ack_o;
        flt_p = (p == 0) ? i_fault_o : d_fault_o;
        ent_p = (p == 0) ? i_ent_o : d_ent_o;
        if (ack_p) begin
          chk("rnd_ack_outstanding", st[p], 1);
          chk("rnd_ent", ent_p, ent_of(ra[p]));
          chk("rnd_fault", flt_p, fault_of(ra[p]));
          if (flt_p) chk("rnd_fault_addr", fault_addr_o, ra[p]);
          acks++;
          st[p] = 0;
          if (p == 0) i_lookup = 1'b0; else d_lookup = 1'b0;
        end else if (st[p] == 1) begin
          wt[p]++;
          if (wt[p] > 200) begin
            chk("rnd_wait_bound", wt[p], 200);
            st[p] = 0;
            if (p == 0) i_lookup = 1'b0; else d_lookup = 1'b0;
          end
        end else if (k < 2800 && $urandom_range(0, 2) == 0) begin
          ra[p] = (32'($urandom_range(0, 31)) << 12) | 32'($urandom_range(0, 4095));
          st[p] = 1;
          wt[p] = 0;
          if (p == 0) begin
            i_addr_i = ra[p]; i_lookup = 1'b1;
          end else begin
            d_addr_i = ra[p]; d_lookup = 1'b1;
          end
        end
      end
      if ($urandom_range(0, 39) == 0) begin
        base_we = 1'b1;
        base_i = $urandom;
      end else begin
        base_we = 1'b0;
      end
    end
    base_we = 1'b0;
    chk("rnd_all_served", st[0] + st[1], 0);
`ifndef TLB_ARB_MICRO_EN
    chk("rnd_walks_eq_acks", walks - w0, acks);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
